// File: rtl/prbs15_pkg.sv
//==============================================================================
// Package : prbs15_pkg
// Desc    : Shared types, constants and the 15-step LFSR advance function for
//           the x^15+x^14+1 word scrambler.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package prbs15_pkg;

    localparam int LFSR_W = 15;

    typedef logic [LFSR_W-1:0] prbs_word_t;

    localparam prbs_word_t DEFAULT_SEED = 15'h7FFF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One keystream word is fifteen single-bit steps of L(s) = {s[13:0], s[14]^s[13]}
    function automatic prbs_word_t prbs15_adv15(input prbs_word_t s);
        prbs_word_t v;
        v = s;
        for (int i = 0; i < LFSR_W; i++) begin
            v = {v[13:0], v[14] ^ v[13]};
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prbs15_scramble_ctrl_if.sv
//==============================================================================
// Interface : prbs15_scramble_ctrl_if
// Desc      : Input and output valid/ready word streams of the PRBS15 scrambler.
// Rev       : 1.0  initial release
//==============================================================================
`default_nettype none

interface prbs15_scramble_ctrl_if;
    import prbs15_pkg::*;

    logic       s_valid;
    logic       s_ready;
    prbs_word_t s_data;
    logic       s_sof;
    logic       s_eof;

    logic       m_valid;
    logic       m_ready;
    prbs_word_t m_data;
    logic       m_sof;
    logic       m_eof;

    modport master (
        output s_valid, s_data, s_sof, s_eof, m_ready,
        input  s_ready, m_valid, m_data, m_sof, m_eof
    );

    modport slave (
        input  s_valid, s_data, s_sof, s_eof, m_ready,
        output s_ready, m_valid, m_data, m_sof, m_eof
    );

endinterface

`default_nettype wire

// File: rtl/prbs15_lfsr.sv
//==============================================================================
// Module : prbs15_lfsr
// Desc   : PRBS15 state register; key is the next keystream word L^15 of the
//          (optionally freshly loaded) state.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module prbs15_lfsr
    import prbs15_pkg::*;
#(
    parameter prbs_word_t RESET_SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  prbs_word_t seed,
    input  logic       advance,
    output prbs_word_t key
);

    prbs_word_t r_state;
    prbs_word_t w_base;

    // A load in the same cycle makes the key derive from the new seed
    assign w_base = load ? seed : r_state;
    assign key    = prbs15_adv15(w_base);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESET_SEED;
        end else if (advance) begin
            r_state <= key;
        end else if (load) begin
            r_state <= w_base;
        end
    end

endmodule

`default_nettype wire

// File: rtl/prbs15_scramble_ctrl.sv
//==============================================================================
// Module : prbs15_scramble_ctrl
// Desc   : Frame controller for the PRBS15 TX word scrambler with one
//          registered output stage. Define SCR_BYPASS_EN to add bypass_i.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module prbs15_scramble_ctrl
    import prbs15_pkg::*;
#(
    parameter prbs_word_t DEFAULT_SEED = prbs15_pkg::DEFAULT_SEED,
    parameter int         MAX_WORDS    = 1024,
    parameter int         CNT_W        = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_i,
    input  prbs_word_t            seed_i,
`ifdef SCR_BYPASS_EN
    input  logic                  bypass_i,
`endif
    prbs15_scramble_ctrl_if.slave bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err
);

    localparam logic [CNT_W-1:0] c_ovf_cnt = CNT_W'(MAX_WORDS + 1);

    state_t           r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
    logic             w_accept, w_fwd, w_load, w_advance, w_err, w_done, w_bypass;
    prbs_word_t       w_seed, w_key;

    logic             r_m_valid, r_m_sof, r_m_eof, r_err, r_done;
    prbs_word_t       r_m_data;

`ifdef SCR_BYPASS_EN
    assign w_bypass = bypass_i;
`else
    assign w_bypass = 1'b0;
`endif

    assign bus.s_ready = enable_i & (~r_m_valid | bus.m_ready);
    assign w_accept    = bus.s_valid & bus.s_ready;
    assign w_seed      = (seed_i == '0) ? DEFAULT_SEED : seed_i;
    assign w_advance   = w_fwd & ~w_bypass;

    prbs15_lfsr #(
        .RESET_SEED (DEFAULT_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_load),
        .seed    (w_seed),
        .advance (w_advance),
        .key     (w_key)
    );

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        w_fwd        = 1'b0;
        w_err        = 1'b0;
        w_done       = 1'b0;
        // Saturate so an extremely long frame cannot wrap and flag twice
        w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

        if (w_accept) begin
            if (bus.s_sof) begin
                w_load       = 1'b1;
                w_fwd        = 1'b1;
                w_err        = (r_state == RUN);
                w_cnt_next   = CNT_W'(1);
                w_next_state = RUN;
            end else if (r_state == RUN) begin
                w_fwd      = 1'b1;
                w_cnt_next = w_cnt_inc;
                w_err      = (w_cnt_inc == c_ovf_cnt);
            end else begin
                w_err = 1'b1;
            end

            if (w_fwd && bus.s_eof) begin
                w_next_state = IDLE;
                w_done       = 1'b1;
                w_cnt_next   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_sof   <= 1'b0;
            r_m_eof   <= 1'b0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_fwd) begin
                r_m_valid <= 1'b1;
                r_m_data  <= bus.s_data ^ (w_bypass ? '0 : w_key);
                r_m_sof   <= bus.s_sof;
                r_m_eof   <= bus.s_eof;
            end else if (bus.m_ready) begin
                r_m_valid <= 1'b0;
            end
            r_err  <= w_err;
            r_done <= w_done;
        end
    end

    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign bus.m_sof   = r_m_sof;
    assign bus.m_eof   = r_m_eof;
    assign busy        = (r_state == RUN);
    assign frame_done  = r_done;
    assign err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_prbs15_scramble_ctrl.sv
//==============================================================================
// Module : tb_prbs15_scramble_ctrl
// Desc   : Directed self-checking bench for prbs15_scramble_ctrl.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_prbs15_scramble_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable_i;
    logic [14:0] seed_i;
`ifdef SCR_BYPASS_EN
    logic        bypass_i;
`endif
    logic        busy;
    logic        frame_done;
    logic        err;

    int checks = 0;
    int errors = 0;

    prbs15_scramble_ctrl_if bus_if ();

    prbs15_scramble_ctrl #(
        .MAX_WORDS (1024),
        .CNT_W     (11)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_i   (enable_i),
        .seed_i     (seed_i),
`ifdef SCR_BYPASS_EN
        .bypass_i   (bypass_i),
`endif
        .bus        (bus_if),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Golden keystream step: fifteen applications of {s[13:0], s[14]^s[13]}
    function automatic logic [14:0] kadv(input logic [14:0] s);
        logic [14:0] v;
        v = s;
        for (int i = 0; i < 15; i++) v = {v[13:0], v[14] ^ v[13]};
        return v;
    endfunction

    function automatic logic [17:0] mout();
        return {bus_if.m_valid, bus_if.m_sof, bus_if.m_eof, bus_if.m_data};
    endfunction

    function automatic logic [2:0] st();
        return {busy, frame_done, err};
    endfunction

    task automatic xfer(input logic sof, input logic eof, input logic [14:0] seed, input logic [14:0] data);
        @(negedge clk);
        bus_if.s_valid = 1'b1;
        bus_if.s_sof   = sof;
        bus_if.s_eof   = eof;
        bus_if.s_data  = data;
        seed_i         = seed;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus_if.s_valid = 1'b0;
        bus_if.s_sof   = 1'b0;
        bus_if.s_eof   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mout() !== 18'h0) begin
            errors++;
            $display("FAIL reset_mout got=%h exp=00000", mout());
        end
        checks++;
        if (st() !== 3'b000) begin
            errors++;
            $display("FAIL reset_status busy/done/err got=%b exp=000", st());
        end
        checks++;
        if (bus_if.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_s_ready got=%b exp=1", bus_if.s_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_two_word();
        xfer(1'b1, 1'b0, 15'h0000, 15'h0000);
        checks++;
        if (mout() !== {3'b110, 15'h0001}) begin
            errors++;
            $display("FAIL t1_w1 v/sof/eof/data got=%h exp=%h", mout(), {3'b110, 15'h0001});
        end
        checks++;
        if (st() !== 3'b100) begin
            errors++;
            $display("FAIL t1_w1_status got=%b exp=100", st());
        end
        xfer(1'b0, 1'b1, 15'h0000, 15'h0000);
        checks++;
        if (mout() !== {3'b101, 15'h0003}) begin
            errors++;
            $display("FAIL t1_w2 v/sof/eof/data got=%h exp=%h", mout(), {3'b101, 15'h0003});
        end
        checks++;
        if (st() !== 3'b010) begin
            errors++;
            $display("FAIL t1_w2_status got=%b exp=010", st());
        end
        idle(1);
        checks++;
        if ({bus_if.m_valid, st()} !== 4'b0000) begin
            errors++;
            $display("FAIL t1_drain m_valid/busy/done/err got=%b exp=0000", {bus_if.m_valid, st()});
        end
    endtask

    task automatic test_one_word();
        xfer(1'b1, 1'b1, 15'h0000, 15'h7FFF);
        checks++;
        if (mout() !== {3'b111, 15'h7FFE}) begin
            errors++;
            $display("FAIL t2_sofeof got=%h exp=%h", mout(), {3'b111, 15'h7FFE});
        end
        checks++;
        if (st() !== 3'b010) begin
            errors++;
            $display("FAIL t2_status got=%b exp=010", st());
        end
        xfer(1'b1, 1'b1, 15'h0001, 15'h1234);
        checks++;
        if (mout() !== {3'b111, 15'h1237}) begin
            errors++;
            $display("FAIL t2_seed1 got=%h exp=%h", mout(), {3'b111, 15'h1237});
        end
        idle(1);
    endtask

    task automatic test_backpressure();
        xfer(1'b1, 1'b0, 15'h0000, 15'h0000);
        checks++;
        if (mout() !== {3'b110, 15'h0001}) begin
            errors++;
            $display("FAIL t3_w1 got=%h exp=%h", mout(), {3'b110, 15'h0001});
        end
        @(negedge clk);
        bus_if.s_valid = 1'b1;
        bus_if.s_sof   = 1'b0;
        bus_if.s_eof   = 1'b0;
        bus_if.s_data  = 15'h0000;
        bus_if.m_ready = 1'b0;
        #1;
        checks++;
        if (bus_if.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL t3_s_ready got=%b exp=0", bus_if.s_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({bus_if.s_ready, mout()} !== {1'b0, 3'b110, 15'h0001}) begin
                errors++;
                $display("FAIL t3_hold cycle %0d s_ready/mout got=%h exp=%h", i,
                         {bus_if.s_ready, mout()}, {1'b0, 3'b110, 15'h0001});
            end
        end
        @(negedge clk);
        bus_if.m_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, mout()} !== {1'b1, 3'b100, 15'h0003}) begin
            errors++;
            $display("FAIL t3_release busy/mout got=%h exp=%h", {busy, mout()}, {1'b1, 3'b100, 15'h0003});
        end
        xfer(1'b0, 1'b1, 15'h0000, 15'h0000);
        checks++;
        if ({st(), mout()} !== {3'b010, 3'b101, 15'h0005}) begin
            errors++;
            $display("FAIL t3_w3 status/mout got=%h exp=%h", {st(), mout()}, {3'b010, 3'b101, 15'h0005});
        end
        @(negedge clk);
        enable_i       = 1'b0;
        bus_if.s_valid = 1'b1;
        bus_if.s_sof   = 1'b1;
        bus_if.s_eof   = 1'b1;
        #1;
        checks++;
        if (bus_if.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL t3_disable_ready got=%b exp=0", bus_if.s_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus_if.m_valid, st()} !== 4'b0000) begin
            errors++;
            $display("FAIL t3_disable_hold m_valid/status got=%b exp=0000", {bus_if.m_valid, st()});
        end
        @(negedge clk);
        enable_i       = 1'b1;
        bus_if.s_valid = 1'b0;
        bus_if.s_sof   = 1'b0;
        bus_if.s_eof   = 1'b0;
    endtask

    task automatic test_no_sof();
        idle(2);
        xfer(1'b0, 1'b0, 15'h0000, 15'h5555);
        checks++;
        if ({bus_if.m_valid, st()} !== 4'b0001) begin
            errors++;
            $display("FAIL t4_drop m_valid/busy/done/err got=%b exp=0001", {bus_if.m_valid, st()});
        end
        xfer(1'b1, 1'b1, 15'h0000, 15'h0000);
        checks++;
        if ({st(), mout()} !== {3'b010, 3'b111, 15'h0001}) begin
            errors++;
            $display("FAIL t4_recover status/mout got=%h exp=%h", {st(), mout()}, {3'b010, 3'b111, 15'h0001});
        end
        idle(1);
    endtask

    task automatic test_sof_in_run_and_long();
        logic [14:0] ms;
        logic [14:0] d;
        logic [14:0] exp_d;
        int          mism;
        int          err_cnt;
        int          err_at;
        logic        last_done;
        xfer(1'b1, 1'b0, 15'h0000, 15'h0000);
        xfer(1'b0, 1'b0, 15'h0000, 15'h0000);
        checks++;
        if ({st(), mout()} !== {3'b100, 3'b100, 15'h0003}) begin
            errors++;
            $display("FAIL t5_pre status/mout got=%h exp=%h", {st(), mout()}, {3'b100, 3'b100, 15'h0003});
        end
        xfer(1'b1, 1'b0, 15'h0000, 15'h0000);
        checks++;
        if ({st(), mout()} !== {3'b101, 3'b110, 15'h0001}) begin
            errors++;
            $display("FAIL t5_sof_run status/mout got=%h exp=%h", {st(), mout()}, {3'b101, 3'b110, 15'h0001});
        end
        xfer(1'b0, 1'b1, 15'h0000, 15'h0000);
        checks++;
        if ({st(), mout()} !== {3'b010, 3'b101, 15'h0003}) begin
            errors++;
            $display("FAIL t5_restart_eof status/mout got=%h exp=%h", {st(), mout()}, {3'b010, 3'b101, 15'h0003});
        end

        mism      = 0;
        err_cnt   = 0;
        err_at    = 0;
        last_done = 1'b0;
        ms        = 15'h2D4B;
        for (int k = 1; k <= 1025; k++) begin
            d  = 15'($urandom);
            ms = kadv(ms);
            xfer(k == 1, k == 1025, 15'h2D4B, d);
            exp_d = d ^ ms;
            if (bus_if.m_data !== exp_d || bus_if.m_valid !== 1'b1) begin
                if (mism == 0) $display("word %0d of long frame: got=%h exp=%h", k, bus_if.m_data, exp_d);
                mism++;
            end
            if (err === 1'b1) begin
                err_cnt++;
                err_at = k;
            end
            if (k == 1025) last_done = frame_done;
        end
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL t5_long_data mismatching words got=%0d exp=0", mism);
        end
        checks++;
        if (err_cnt != 1 || err_at != 1025) begin
            errors++;
            $display("FAIL t5_long_err pulses=%0d last_at=%0d exp pulses=1 at=1025", err_cnt, err_at);
        end
        checks++;
        if (last_done !== 1'b1) begin
            errors++;
            $display("FAIL t5_long_done got=%b exp=1", last_done);
        end
        idle(1);
    endtask

    task automatic test_reset_mid();
        logic [14:0] ms;
        logic [14:0] d;
        xfer(1'b1, 1'b0, 15'h0ABC, 15'h1111);
        xfer(1'b0, 1'b0, 15'h0ABC, 15'h2222);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({st(), mout()} !== 21'h0) begin
            errors++;
            $display("FAIL t6_async_reset status/mout got=%h exp=000000", {st(), mout()});
        end
        @(negedge clk);
        rst_n          = 1'b1;
        bus_if.s_valid = 1'b0;
        bus_if.s_sof   = 1'b0;
        ms             = 15'h7FFF;
        for (int k = 0; k < 4; k++) begin
            d  = 15'($urandom);
            ms = kadv(ms);
            xfer(k == 0, k == 3, 15'h0000, d);
            checks++;
            if ({frame_done, mout()} !== {(k == 3), 1'b1, (k == 0), (k == 3), d ^ ms}) begin
                errors++;
                $display("FAIL t6_frame word %0d done/mout got=%h exp=%h", k, {frame_done, mout()},
                         {(k == 3), 1'b1, (k == 0), (k == 3), d ^ ms});
            end
        end
        idle(1);
    endtask

    initial begin
        rst_n          = 1'b0;
        enable_i       = 1'b1;
        seed_i         = 15'h0000;
`ifdef SCR_BYPASS_EN
        bypass_i       = 1'b0;
`endif
        bus_if.s_valid = 1'b0;
        bus_if.s_sof   = 1'b0;
        bus_if.s_eof   = 1'b0;
        bus_if.s_data  = 15'h0000;
        bus_if.m_ready = 1'b1;

        test_reset();
        test_two_word();
        test_one_word();
        test_backpressure();
        test_no_sof();
        test_sof_in_run_and_long();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
